instr_fetch_unit: RTL

- Fetch stage for the 16-bit single-cycle-derived MIPS core.
- Holds the program counter and issues instruction reads to a variable-latency instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small queue and presents them to decode as `ir` and `ir_pc` under a valid/ready handshake.
- Takes branch redirects from execute and flushes wrong-path work.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/fetch_queue.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          INSTR_W          = 16;
    localparam logic [15:0] PC_INCR          = 16'd2;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        logic [15:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses are halfword aligned; bit 0 is always dropped.
    function automatic logic [15:0] align_pc(input logic [15:0] pc);
        return pc & 16'hFFFE;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory request/response, decode handoff and redirect signals of the fetch stage.
// master = fetch unit side, slave = memory/decode/execute side.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [15:0]        imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               ir_valid;
    logic               ir_ready;
    logic [INSTR_W-1:0] ir;
    logic [15:0]        ir_pc;
    logic               redirect;
    logic [15:0]        redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, ir_valid, ir, ir_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready,
               redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, ir_valid, ir, ir_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready,
               redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries feeding decode.
// The head is the storage word at the read pointer, so it holds while not popped.
// Flush wins over push; a pop in the flush cycle has already been taken by decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Pointer, occupancy and storage update; storage clears on reset so the head reads zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited requests to a variable-latency instruction memory,
// in-order responses tagged with their PC, queue to decode, and redirect flush.
// Optional build macro: FETCH_PERF_EN adds saturating fetch_count / flush_count ports.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          QDEPTH   = 2,
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic                clock,
    input logic                reset,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_count,
    output logic [15:0]        flush_count
`endif
);

    localparam int          CW        = $clog2(QDEPTH + 1);
    localparam int          TDEPTH    = 2 ** CW;
    localparam logic [CW:0] QDEPTH_W  = (CW + 1)'(QDEPTH);
    localparam logic [CW-1:0] OUTST_MAX = '1;

    logic [15:0]   fetch_pc;
    logic [CW-1:0] occ;
    logic [CW-1:0] outst;
    logic [CW-1:0] discard;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_fire;
    logic          push_ok;
    logic          pop_fire;

    logic [15:0]   tag_mem [TDEPTH];
    logic [CW-1:0] tag_wr;
    logic [CW-1:0] tag_rd;

    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Discarded responses still count as outstanding, so after a redirect outst can exceed
    // QDEPTH; issuing stops at the top of its range so it never wraps.
    assign credit_used = {1'b0, occ} + {1'b0, outst} - {1'b0, discard};
    assign bus.imem_req_valid = !reset && (credit_used < QDEPTH_W) && (outst != OUTST_MAX);
    assign bus.imem_addr      = fetch_pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = bus.imem_rsp_valid && (outst != '0);
    assign push_ok  = rsp_fire && (discard == '0) && !bus.redirect;
    assign pop_fire = bus.ir_valid && bus.ir_ready;

    assign push_entry.pc    = tag_mem[tag_rd];
    assign push_entry.instr = bus.imem_rsp_data;

    assign bus.ir_valid = (occ != '0);
    assign bus.ir       = head.instr;
    assign bus.ir_pc    = head.pc;

    // Program counter: redirect beats sequential advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= align_pc(RESET_PC);
        end else if (bus.redirect) begin
            fetch_pc <= align_pc(bus.redirect_pc);
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + PC_INCR;
        end
    end

    // Outstanding request count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outst <= '0;
        end else begin
            case ({req_fire, rsp_fire})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase
        end
    end

    // Responses to drop: everything still in flight at a redirect, including its own request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            discard <= '0;
        end else if (bus.redirect) begin
            discard <= outst + CW'(req_fire) - CW'(rsp_fire);
        end else if (rsp_fire && (discard != '0)) begin
            discard <= discard - CW'(1);
        end
    end

    // PC tag FIFO, one entry per outstanding request, popped by every accepted response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_wr <= '0;
            tag_rd <= '0;
            for (int i = 0; i < TDEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                tag_mem[tag_wr] <= fetch_pc;
                tag_wr          <= tag_wr + CW'(1);
            end
            if (rsp_fire) begin
                tag_rd <= tag_rd + CW'(1);
            end
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push_ok),
        .push_data (push_entry),
        .pop       (pop_fire),
        .flush     (bus.redirect),
        .head      (head),
        .count     (occ)
    );

`ifdef FETCH_PERF_EN
    // Saturating counters of delivered fetches and redirect cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push_ok && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (bus.redirect && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
